// File: rtl/ritmo_player.sv
// ritmo_player: plays one count-in slot and then a BEATS-slot LED beat pattern on each start edge.
module ritmo_player #(
  parameter int SLOT  = 25_000_000,
  parameter int PULSE = 12_500_000,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BEATS-1:0] pattern,
  output logic             beat_led,
  output logic             slot_strobe,
  output logic [3:0]       slot_idx,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(SLOT);
  localparam int PE = PULSE > SLOT ? SLOT : PULSE;
  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT - 1);
  localparam logic [3:0] LAST_IDX = 4'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, LEAD, PLAY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [BEATS-1:0] pat_q, pat_d, pat_sh;
  logic start_q, led_q, led_d, strobe_q, strobe_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    pat_d = pat_q;
    strobe_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !start_q) begin
          state_d = LEAD;
          pat_d = pattern;
          busy_d = 1'b1;
        end
      end
      LEAD: if (cnt_q == LAST_CNT) begin
        state_d = PLAY;
        cnt_d = '0;
        idx_d = '0;
        strobe_d = 1'b1;
      end
      PLAY: if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        if (idx_q < LAST_IDX) begin
          idx_d = idx_q + 4'd1;
          strobe_d = 1'b1;
        end else begin
          state_d = DONE;
          idx_d = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    // led is registered, so it is derived from the slot the next cycle belongs to
    pat_sh = pat_q >> idx_d;
    led_d = state_d == PLAY && pat_sh[0] && 32'(cnt_d) < PE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      pat_q <= '0;
      led_q <= 1'b0;
      strobe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pat_q <= pat_d;
      led_q <= led_d;
      strobe_q <= strobe_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign beat_led = led_q;
  assign slot_strobe = strobe_q;
  assign slot_idx = idx_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_ritmo_player.sv
// tb_ritmo_player: two builds (PULSE=3 and clamped PULSE=10) driven in lockstep against a phrase-timeline model.
module tb_ritmo_player;
  localparam int SLOT = 8;
  localparam int BEATS = 4;
  localparam int PA = 3;
  localparam int PB = 10;
  localparam int LEN = (BEATS + 1) * SLOT;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [BEATS-1:0] pattern = '0;
  logic a_led, a_str, a_busy, a_done, b_led, b_str, b_busy, b_done;
  logic [3:0] a_idx, b_idx;
  int tests = 0, fails = 0, phase = -1, ndone = 0, n0;
  logic sprev = 1'b0;
  logic [BEATS-1:0] lp = '0;

  ritmo_player #(.SLOT(SLOT), .PULSE(PA), .BEATS(BEATS)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .beat_led(a_led),
    .slot_strobe(a_str), .slot_idx(a_idx), .busy(a_busy), .done(a_done));
  ritmo_player #(.SLOT(SLOT), .PULSE(PB), .BEATS(BEATS)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .beat_led(b_led),
    .slot_strobe(b_str), .slot_idx(b_idx), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (phase %0d)", tag, obs, exp, phase);
    end
  endtask

  function automatic logic in_play();
    return phase >= SLOT && phase < LEN;
  endfunction

  function automatic logic exp_led(input int pulse);
    int pe;
    pe = pulse < SLOT ? pulse : SLOT;
    return in_play() && lp[phase / SLOT - 1] && (phase % SLOT) < pe;
  endfunction

  task automatic step(input logic s, input logic r);
    int ei;
    start = s;
    rst = r;
    @(posedge clk);
    if (r) begin
      phase = -1;
      sprev = 1'b0;
    end else begin
      if (phase < 0) begin
        if (s && !sprev) begin
          phase = 0;
          lp = pattern;
        end
      end else if (phase == LEN) phase = -1;
      else phase++;
      sprev = s;
    end
    #1;
    ei = in_play() ? phase / SLOT - 1 : 0;
    chk("busy_a", 32'(a_busy), 32'(phase >= 0 && phase < LEN));
    chk("busy_b", 32'(b_busy), 32'(phase >= 0 && phase < LEN));
    chk("done_a", 32'(a_done), 32'(phase == LEN));
    chk("done_b", 32'(b_done), 32'(phase == LEN));
    chk("strobe_a", 32'(a_str), 32'(in_play() && phase % SLOT == 0));
    chk("strobe_b", 32'(b_str), 32'(in_play() && phase % SLOT == 0));
    chk("idx_a", 32'(a_idx), 32'(ei));
    chk("idx_b", 32'(b_idx), 32'(ei));
    chk("led_a", 32'(a_led), 32'(exp_led(PA)));
    chk("led_b", 32'(b_led), 32'(exp_led(PB)));
    if (a_done) ndone++;
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) step(s, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run(50, 1'b0);
    // basic phrase, start held high for 100 cycles: exactly one phrase
    pattern = 4'b1011;
    n0 = ndone;
    run(100, 1'b1);
    chk("held_done_cnt", 32'(ndone - n0), 32'd1);
    run(5, 1'b0);
    // re-trigger mid-phrase is ignored
    n0 = ndone;
    run(3, 1'b1);
    run(17, 1'b0);
    run(10, 1'b1);
    run(30, 1'b0);
    chk("retrig_done_cnt", 32'(ndone - n0), 32'd1);
    // reset mid-phrase: no done, then a fresh phrase with a new pattern
    pattern = 4'b1111;
    n0 = ndone;
    run(25, 1'b1);
    step(1'b0, 1'b1);
    run(14, 1'b0);
    chk("abort_done_cnt", 32'(ndone - n0), 32'd0);
    pattern = 4'b0101;
    run(1, 1'b1);
    run(45, 1'b0);
    // silent pattern
    pattern = 4'b0000;
    run(1, 1'b1);
    run(45, 1'b0);
    // clamp: adjacent active slots; pattern change mid-phrase ignored
    pattern = 4'b0110;
    run(1, 1'b1);
    pattern = 4'b1111;
    run(45, 1'b0);
    // start edge exactly during DONE, then as early as possible afterwards
    pattern = 4'b1001;
    run(1, 1'b1);
    run(39, 1'b0);
    step(1'b1, 1'b0);
    run(2, 1'b0);
    run(45, 1'b1);
    run(2, 1'b0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      pattern = 4'($urandom);
      step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 199) == 0));
    end
    run(45, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
